// File: rtl/seq_divider_if.sv
// Handshake bundle between a divider and its producer/consumer.
// The master side drives operands and accepts results; the slave side is the divider.
interface seq_divider_if #(
    parameter int BITWIDTH = 16
);
    logic                in_valid;
    logic                in_ready;
    logic [BITWIDTH-1:0] a;
    logic [BITWIDTH-1:0] b;
    logic                out_valid;
    logic                out_ready;
    logic [BITWIDTH-1:0] quotient;
    logic [BITWIDTH-1:0] remainder;
    logic                div_by_zero;
    logic                overflow;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_by_zero, overflow
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, quotient, remainder, div_by_zero, overflow
    );
endinterface

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider with quotient/remainder, optional two's-complement
// operands, UNROLL quotient bits resolved per cycle, and valid/ready on both sides.
// One operation is in flight at a time: IDLE accepts, CALC iterates, DONE holds results.
module seq_divider #(
    parameter int BITWIDTH = 16,
    parameter int SIGNED   = 1,
    parameter int UNROLL   = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    seq_divider_if.slave   bus
);

    localparam int W        = BITWIDTH;
    localparam int STEPS    = (UNROLL > 0) ? (BITWIDTH / UNROLL) : 1;
    localparam int CNT_W    = $clog2(STEPS + 1);
    localparam bit IS_SIGNED = (SIGNED != 0);
    localparam logic [W-1:0] ONE     = {{(W-1){1'b0}}, 1'b1};
    localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};

    if (BITWIDTH < 2) begin : g_bad_width
        $error("seq_divider: BITWIDTH must be at least 2");
    end
    if (UNROLL < 1) begin : g_bad_unroll
        $error("seq_divider: UNROLL must be at least 1");
    end else if ((BITWIDTH % UNROLL) != 0) begin : g_bad_split
        $error("seq_divider: UNROLL must divide BITWIDTH evenly");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Working registers of the iteration
    logic [W-1:0]   dvd_q, dvd_d;        // dividend magnitude, consumed MSB first
    logic [W-1:0]   dvs_q, dvs_d;        // divisor magnitude
    logic [W:0]     prem_q, prem_d;      // partial remainder, one extra bit for the shift carry
    logic [W-1:0]   quo_q, quo_d;        // quotient magnitude being assembled
    logic [CNT_W-1:0] cnt_q, cnt_d;      // CALC cycles still to run
    logic           qneg_q, qneg_d;
    logic           rneg_q, rneg_d;
    logic           ovf_pend_q, ovf_pend_d;
    logic           dz_pend_q, dz_pend_d;

    // Result registers presented on the bus
    logic [W-1:0]   quot_q, quot_d;
    logic [W-1:0]   rem_q, rem_d;
    logic           dz_q, dz_d;
    logic           ovf_q, ovf_d;

    logic           accept;
    logic           finish;
    logic           a_neg, b_neg;
    logic [W-1:0]   a_mag, b_mag;
    logic [W:0]     step_prem;
    logic [W-1:0]   step_dvd;
    logic [W-1:0]   step_quo;

    function automatic logic [W-1:0] negate(input logic [W-1:0] x);
        return ~x + ONE;
    endfunction

    assign accept = bus.in_valid && (state_q == IDLE);
    // A divide-by-zero skips the iteration and completes on its first CALC edge.
    assign finish = (state_q == CALC) && (dz_pend_q || (cnt_q == CNT_W'(1)));

    assign a_neg = IS_SIGNED && bus.a[W-1];
    assign b_neg = IS_SIGNED && bus.b[W-1];
    // Negating the most-negative value yields 100..0, which is its correct unsigned magnitude.
    assign a_mag = a_neg ? negate(bus.a) : bus.a;
    assign b_mag = b_neg ? negate(bus.b) : bus.b;

    assign bus.quotient    = quot_q;
    assign bus.remainder   = rem_q;
    assign bus.div_by_zero = dz_q;
    assign bus.overflow    = ovf_q;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = CALC;
            CALC:    if (finish) state_d = DONE;
            DONE:    if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs depend on state only, so neither valid nor ready sees the opposite side combinationally
    always_comb begin
        bus.in_ready  = (state_q == IDLE);
        bus.out_valid = (state_q == DONE);
    end

    // UNROLL chained restoring steps: shift in the next dividend bit, trial-subtract, keep if non-negative
    always_comb begin
        logic [W:0]   p;
        logic [W-1:0] d;
        logic [W-1:0] qq;
        logic [W+1:0] diff;
        p    = prem_q;
        d    = dvd_q;
        qq   = quo_q;
        diff = '0;
        for (int i = 0; i < UNROLL; i++) begin
            p    = {p[W-1:0], d[W-1]};
            d    = {d[W-2:0], 1'b0};
            diff = {1'b0, p} - {2'b00, dvs_q};
            if (!diff[W+1]) begin
                p  = diff[W:0];
                qq = {qq[W-2:0], 1'b1};
            end else begin
                qq = {qq[W-2:0], 1'b0};
            end
        end
        step_prem = p;
        step_dvd  = d;
        step_quo  = qq;
    end

    // Datapath next-state: operand capture on accept, iteration in CALC, sign-corrected results on the last cycle
    always_comb begin
        dvd_d      = dvd_q;
        dvs_d      = dvs_q;
        prem_d     = prem_q;
        quo_d      = quo_q;
        cnt_d      = cnt_q;
        qneg_d     = qneg_q;
        rneg_d     = rneg_q;
        ovf_pend_d = ovf_pend_q;
        dz_pend_d  = dz_pend_q;
        quot_d     = quot_q;
        rem_d      = rem_q;
        dz_d       = dz_q;
        ovf_d      = ovf_q;

        if (accept) begin
            dz_d       = 1'b0;
            ovf_d      = 1'b0;
            dz_pend_d  = (bus.b == '0);
            // A zero divisor keeps the raw dividend so it can be returned as the remainder.
            dvd_d      = (bus.b == '0) ? bus.a : a_mag;
            dvs_d      = b_mag;
            prem_d     = '0;
            quo_d      = '0;
            cnt_d      = CNT_W'(STEPS);
            qneg_d     = a_neg ^ b_neg;
            rneg_d     = a_neg;
            ovf_pend_d = IS_SIGNED && (bus.a == MOST_NEG) && (bus.b == '1);
        end else if (state_q == CALC) begin
            if (dz_pend_q) begin
                quot_d = '1;
                rem_d  = dvd_q;
                dz_d   = 1'b1;
                ovf_d  = 1'b0;
            end else begin
                prem_d = step_prem;
                dvd_d  = step_dvd;
                quo_d  = step_quo;
                cnt_d  = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    quot_d = qneg_q ? negate(step_quo) : step_quo;
                    rem_d  = rneg_q ? negate(step_prem[W-1:0]) : step_prem[W-1:0];
                    dz_d   = 1'b0;
                    ovf_d  = ovf_pend_q;
                end
            end
        end
    end

    // Datapath registers; reset clears everything so outputs come up zeroed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dvd_q      <= '0;
            dvs_q      <= '0;
            prem_q     <= '0;
            quo_q      <= '0;
            cnt_q      <= '0;
            qneg_q     <= 1'b0;
            rneg_q     <= 1'b0;
            ovf_pend_q <= 1'b0;
            dz_pend_q  <= 1'b0;
            quot_q     <= '0;
            rem_q      <= '0;
            dz_q       <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            dvd_q      <= dvd_d;
            dvs_q      <= dvs_d;
            prem_q     <= prem_d;
            quo_q      <= quo_d;
            cnt_q      <= cnt_d;
            qneg_q     <= qneg_d;
            rneg_q     <= rneg_d;
            ovf_pend_q <= ovf_pend_d;
            dz_pend_q  <= dz_pend_d;
            quot_q     <= quot_d;
            rem_q      <= rem_d;
            dz_q       <= dz_d;
            ovf_q      <= ovf_d;
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: four instances (signed/unsigned x UNROLL 1/4) sharing one clock.
// Directed cases with hand-derived results, then randomized operands against an arithmetic model.
module tb_seq_divider;

    localparam int W = 16;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    logic         iv   [4];
    logic [W-1:0] ia   [4];
    logic [W-1:0] ib   [4];
    logic         ordy [4];
    logic         rdy  [4];
    logic         ovl  [4];
    logic [W-1:0] qv   [4];
    logic [W-1:0] rv   [4];
    logic         dzv  [4];
    logic         ofv  [4];

    int checks = 0;
    int errors = 0;

    // k=0: signed UNROLL=1, k=1: unsigned UNROLL=1, k=2: signed UNROLL=4, k=3: unsigned UNROLL=4
    for (genvar k = 0; k < 4; k++) begin : g_dut
        seq_divider_if #(.BITWIDTH(W)) bus ();
        assign bus.in_valid  = iv[k];
        assign bus.a         = ia[k];
        assign bus.b         = ib[k];
        assign bus.out_ready = ordy[k];
        assign rdy[k]        = bus.in_ready;
        assign ovl[k]        = bus.out_valid;
        assign qv[k]         = bus.quotient;
        assign rv[k]         = bus.remainder;
        assign dzv[k]        = bus.div_by_zero;
        assign ofv[k]        = bus.overflow;

        seq_divider #(
            .BITWIDTH(W),
            .SIGNED  ((k % 2 == 0) ? 1 : 0),
            .UNROLL  ((k < 2) ? 1 : 4)
        ) u_dut (
            .clk  (clk),
            .rst_n(rst_n),
            .bus  (bus.slave)
        );
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Arithmetic reference: language division truncates toward zero and % follows the dividend.
    task automatic ref_div(input bit sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                           output logic [W-1:0] q, output logic [W-1:0] r,
                           output logic dz, output logic ov);
        int sa, sb, sq, sr;
        dz = (b == 0);
        ov = 1'b0;
        if (b == 0) begin
            q = '1;
            r = a;
        end else if (!sgn) begin
            q = a / b;
            r = a % b;
        end else begin
            sa = int'($signed(a));
            sb = int'($signed(b));
            sq = sa / sb;
            sr = sa % sb;
            q  = sq[W-1:0];
            r  = sr[W-1:0];
            ov = (sa == -(1 << (W - 1))) && (sb == -1);
        end
    endtask

    // Issue one operation on instance k and wait (bounded) for out_valid; lat counts edges after the accept edge.
    task automatic run_op(input int k, input logic [W-1:0] a, input logic [W-1:0] b,
                          output logic [W-1:0] q, output logic [W-1:0] r,
                          output logic dz, output logic ov, output int lat, output logic busy_ok);
        int guard;
        guard = 0;
        while (!rdy[k] && guard < 50) begin
            @(posedge clk);
            #1;
            guard++;
        end
        iv[k] = 1'b1;
        ia[k] = a;
        ib[k] = b;
        @(posedge clk);
        #1;
        iv[k]   = 1'b0;
        ia[k]   = W'($urandom);
        ib[k]   = W'($urandom);
        lat     = 0;
        busy_ok = 1'b1;
        do begin
            if (rdy[k]) busy_ok = 1'b0;
            @(posedge clk);
            #1;
            lat++;
        end while (!ovl[k] && lat < 100);
        if (rdy[k]) busy_ok = 1'b0;
        q  = qv[k];
        r  = rv[k];
        dz = dzv[k];
        ov = ofv[k];
    endtask

    task automatic directed(input string tag, input int k, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [W-1:0] eq, input logic [W-1:0] er,
                            input logic edz, input logic eov, input int elat);
        logic [W-1:0] q, r;
        logic dz, ov, busy_ok;
        int lat;
        run_op(k, a, b, q, r, dz, ov, lat, busy_ok);
        check({tag, "_q"},    32'(q),  32'(eq));
        check({tag, "_r"},    32'(r),  32'(er));
        check({tag, "_dz"},   32'(dz), 32'(edz));
        check({tag, "_ovf"},  32'(ov), 32'(eov));
        check({tag, "_lat"},  32'(lat), 32'(elat));
        check({tag, "_busy"}, 32'(busy_ok), 32'(1));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] q, r, eq, er, a, b;
        logic dz, ov, edz, eov, busy_ok;
        int lat, k, sel;

        for (int i = 0; i < 4; i++) begin
            iv[i]   = 1'b0;
            ia[i]   = '0;
            ib[i]   = '0;
            ordy[i] = 1'b1;
        end
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            check("rst_in_ready",  32'(rdy[i]), 32'(1));
            check("rst_out_valid", 32'(ovl[i]), 32'(0));
            check("rst_quotient",  32'(qv[i]),  32'(0));
            check("rst_remainder", 32'(rv[i]),  32'(0));
            check("rst_dz",        32'(dzv[i]), 32'(0));
            check("rst_ovf",       32'(ofv[i]), 32'(0));
        end
        @(negedge clk);
        rst_n = 1'b1;

        directed("u_100_7",   1, 16'd100,   16'd7,     16'd14,    16'd2,     1'b0, 1'b0, 16);
        directed("s_m7_2",    0, 16'hFFF9,  16'd2,     16'hFFFD,  16'hFFFF,  1'b0, 1'b0, 16);
        directed("s_7_m2",    0, 16'd7,     16'hFFFE,  16'hFFFD,  16'h0001,  1'b0, 1'b0, 16);
        directed("s_dz",      0, 16'h04D2,  16'h0000,  16'hFFFF,  16'h04D2,  1'b1, 1'b0, 1);
        directed("u_dz",      1, 16'h04D2,  16'h0000,  16'hFFFF,  16'h04D2,  1'b1, 1'b0, 1);
        directed("s_ovf",     0, 16'h8000,  16'hFFFF,  16'h8000,  16'h0000,  1'b0, 1'b1, 16);
        directed("s_min_1",   0, 16'h8000,  16'h0001,  16'h8000,  16'h0000,  1'b0, 1'b0, 16);
        directed("u_min_ff",  1, 16'h8000,  16'hFFFF,  16'h0000,  16'h8000,  1'b0, 1'b0, 16);
        directed("s4_100_7",  2, 16'd100,   16'd7,     16'd14,    16'd2,     1'b0, 1'b0, 4);
        directed("s4_dz",     2, 16'h0001,  16'h0000,  16'hFFFF,  16'h0001,  1'b1, 1'b0, 1);

        // Backpressure: DONE must hold its results while out_ready stays low
        ordy[0] = 1'b0;
        run_op(0, 16'd1000, 16'd3, q, r, dz, ov, lat, busy_ok);
        check("bp_q",   32'(q),   32'(333));
        check("bp_r",   32'(r),   32'(1));
        check("bp_lat", 32'(lat), 32'(16));
        repeat (5) begin
            @(posedge clk);
            #1;
            check("bp_out_valid", 32'(ovl[0]), 32'(1));
            check("bp_in_ready",  32'(rdy[0]), 32'(0));
            check("bp_hold_q",    32'(qv[0]),  32'(333));
            check("bp_hold_r",    32'(rv[0]),  32'(1));
            check("bp_hold_dz",   32'(dzv[0]), 32'(0));
        end
        ordy[0] = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_valid", 32'(ovl[0]), 32'(0));
        check("bp_release_ready", 32'(rdy[0]), 32'(1));

        // Reset in the middle of CALC discards the operation immediately
        iv[0] = 1'b1;
        ia[0] = 16'h1234;
        ib[0] = 16'h0003;
        @(posedge clk);
        #1;
        iv[0] = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("mid_busy", 32'(rdy[0]), 32'(0));
        rst_n = 1'b0;
        #1;
        check("mid_rst_in_ready",  32'(rdy[0]), 32'(1));
        check("mid_rst_out_valid", 32'(ovl[0]), 32'(0));
        check("mid_rst_q",         32'(qv[0]),  32'(0));
        check("mid_rst_r",         32'(rv[0]),  32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        directed("after_rst", 0, 16'd50, 16'd5, 16'd10, 16'd0, 1'b0, 1'b0, 16);

        // Randomized operands on the UNROLL=4 instances, biased toward corner values
        for (int i = 0; i < 1000; i++) begin
            k   = 2 + (i % 2);
            a   = W'($urandom);
            b   = W'($urandom);
            sel = int'($urandom_range(0, 9));
            if (sel == 0) b = '0;
            if (sel == 1) b = '1;
            if (sel == 2) a = 16'h8000;
            if (sel == 3) b = W'($urandom_range(1, 15));
            run_op(k, a, b, q, r, dz, ov, lat, busy_ok);
            ref_div(k == 2, a, b, eq, er, edz, eov);
            check("rnd_q",    32'(q),       32'(eq));
            check("rnd_r",    32'(r),       32'(er));
            check("rnd_dz",   32'(dz),      32'(edz));
            check("rnd_ovf",  32'(ov),      32'(eov));
            check("rnd_lat",  32'(lat),     (b == 0) ? 32'(1) : 32'(4));
            check("rnd_busy", 32'(busy_ok), 32'(1));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
